// File: rtl/multirate_mac_scheduler_if.sv
// multirate_mac_scheduler_if: sample, coefficient, multiplier and result signals of the MAC scheduler
interface multirate_mac_scheduler_if #(
  parameter int NUM_TAPS = 16,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 9,
  parameter int PROD_W   = 25,
  parameter int ACC_W    = 29
) ();
  localparam int AW = $clog2(NUM_TAPS);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [3:0]        cfg_decim;
  logic [DATA_W-1:0] mul_din0;
  logic [COEF_W-1:0] mul_din1;
  logic [PROD_W-1:0] mul_dout;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_data;
  logic              busy;
  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_data, cfg_decim, mul_dout, m_ready,
    output s_ready, mul_din0, mul_din1, m_valid, m_data, busy
  );
  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_data, cfg_decim, mul_dout, m_ready,
    input  s_ready, mul_din0, mul_din1, m_valid, m_data, busy
  );
endinterface

// File: rtl/multirate_mac_scheduler.sv
// multirate_mac_scheduler: decimating FIR controller sharing one external multiplier across all taps
module multirate_mac_scheduler #(
  parameter int NUM_TAPS = 16,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 9,
  parameter int PROD_W   = 25,
  parameter int ACC_W    = 29
) (
  input logic ap_clk,
  input logic ap_rst_n,
  multirate_mac_scheduler_if.slave bus
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        r_state;
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_k;
  logic [3:0]        r_phase;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_mdata;
  logic [DATA_W-1:0] r_buf  [NUM_TAPS];
  logic [COEF_W-1:0] r_coef [NUM_TAPS];

  logic              w_idle;
  logic              w_mac;
  logic              w_accept;
  logic [3:0]        w_decim;
  logic              w_last_phase;
  logic              w_last_tap;
  logic [AW-1:0]     w_tap;
  logic [ACC_W-1:0]  w_acc_next;

  assign w_idle       = r_state == S_IDLE;
  assign w_mac        = r_state == S_MAC;
  assign w_accept     = bus.s_valid && w_idle;
  assign w_decim      = bus.cfg_decim == 4'd0 ? 4'd1 : bus.cfg_decim;
  // >= rather than == so lowering the factor mid-group still fires on the next sample
  assign w_last_phase = r_phase >= w_decim - 4'd1;
  assign w_last_tap   = r_k == AW'(NUM_TAPS - 1);
  // r_wp already points past the newest sample, so tap 0 is the newest
  assign w_tap        = r_wp - AW'(1) - r_k;
  assign w_acc_next   = r_acc + {{(ACC_W-PROD_W){bus.mul_dout[PROD_W-1]}}, bus.mul_dout};

  assign bus.s_ready  = w_idle;
  assign bus.busy     = !w_idle;
  assign bus.m_valid  = r_state == S_OUT;
  assign bus.m_data   = r_mdata;
  assign bus.mul_din0 = w_mac ? r_buf[w_tap] : '0;
  assign bus.mul_din1 = w_mac ? r_coef[r_k] : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_k     <= '0;
      r_phase <= '0;
      r_acc   <= '0;
      r_mdata <= '0;
    end else begin
      if (w_accept) begin
        r_wp    <= r_wp + AW'(1);
        r_phase <= w_last_phase ? 4'd0 : r_phase + 4'd1;
      end
      if (w_accept && w_last_phase) begin
        r_state <= S_MAC;
        r_k     <= '0;
        r_acc   <= '0;
      end
      if (w_mac) begin
        r_acc <= w_acc_next;
        r_k   <= r_k + AW'(1);
      end
      if (w_mac && w_last_tap) begin
        r_mdata <= w_acc_next;
        r_state <= S_OUT;
      end
      if (bus.m_valid && bus.m_ready) r_state <= S_IDLE;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if (w_accept) r_buf[r_wp] <= bus.s_data;
      if (bus.coef_we && w_idle) r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end
endmodule

// File: tb/tb_multirate_mac_scheduler.sv
// tb_multirate_mac_scheduler: directed vector table plus corner sequences for the MAC scheduler
module tb_multirate_mac_scheduler;
  typedef struct {
    int              mode;
    logic [3:0]      decim;
    logic [15:0]     sample;
    logic            out;
    longint          exp;
  } vec_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic signed [24:0] w_a;
  logic signed [24:0] w_b;

  always #5 ap_clk = ~ap_clk;

  multirate_mac_scheduler_if bus ();

  assign w_a = $signed(bus.mul_din0);
  assign w_b = $signed({1'b0, bus.mul_din1});
  assign bus.mul_dout = w_a * w_b;

  multirate_mac_scheduler dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int mode, input int decim, input int sample, input bit out, input longint exp);
    vec_t v;
    v.mode = mode;
    v.decim = 4'(decim);
    v.sample = 16'(sample);
    v.out = out;
    v.exp = exp;
    return v;
  endfunction

  task automatic write_coef(input int a, input int v);
    bus.coef_addr = 4'(a);
    bus.coef_data = 9'(v);
    bus.coef_we = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic fill_coef(input int mode);
    for (int k = 0; k < 16; k++) write_coef(k, mode == 1 ? k + 1 : mode == 2 ? 1 : 511);
  endtask

  task automatic send(input logic [15:0] x);
    int n;
    n = 0;
    bus.s_data = x;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n >= 200) check("s_ready_timeout", 0, 1);
    @(posedge ap_clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.m_valid && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n >= 200) check("m_valid_timeout", 0, 1);
  endtask

  task automatic get(input string name, input bit chk, input longint exp);
    wait_valid();
    if (chk) check(name, longint'($signed(bus.m_data)), exp);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int lat;
    int seen;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.cfg_decim = 4'd1;
    bus.m_ready = 1'b1;
    for (int i = 0; i <= 16; i++) tbl.push_back(mk(i == 0 ? 1 : 0, 1, i == 0 ? 1 : 0, 1, i < 16 ? i + 1 : 0));
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mk(i == 1 ? 2 : 0, 4, i, i % 4 == 0, i == 4 ? 10 : i == 8 ? 36 : i == 12 ? 78 : 136));
    tbl.push_back(mk(0, 0, 100, 1, 235));
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mk(i == 1 ? 3 : 0, 8, -32768, i % 8 == 0, i == 8 ? -133857983 : -267911168));

    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_din0", bus.mul_din0, 0);
    check("rst_din1", bus.mul_din1, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("rst_s_ready", bus.s_ready, 1);

    foreach (tbl[i]) begin
      if (tbl[i].mode != 0) fill_coef(tbl[i].mode);
      bus.cfg_decim = tbl[i].decim;
      send(tbl[i].sample);
      if (tbl[i].out) get($sformatf("vec%0d_data", i), 1'b1, tbl[i].exp);
      else begin
        check($sformatf("vec%0d_s_ready", i), bus.s_ready, 1);
        check($sformatf("vec%0d_busy", i), bus.busy, 0);
      end
    end

    bus.cfg_decim = 4'd1;
    fill_coef(1);
    for (int i = 0; i < 16; i++) begin
      send(16'd0);
      get("flush", i == 15, 0);
    end

    bus.m_ready = 1'b0;
    send(16'd1);
    wait_valid();
    bus.coef_addr = 4'd0;
    bus.coef_data = 9'd200;
    for (int c = 0; c < 20; c++) begin
      bus.coef_we = c == 5;
      @(posedge ap_clk);
      #1;
      check("bp_m_data", bus.m_data, 1);
      check("bp_m_valid", bus.m_valid, 1);
      check("bp_s_ready", bus.s_ready, 0);
      check("bp_busy", bus.busy, 1);
    end
    bus.coef_we = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("bp_release_m_valid", bus.m_valid, 0);
    check("bp_release_s_ready", bus.s_ready, 1);
    send(16'd5);
    get("bp_coef_kept", 1'b1, 7);

    bus.coef_addr = 4'd0;
    bus.coef_data = 9'd3;
    bus.coef_we = 1'b1;
    send(16'd1);
    bus.coef_we = 1'b0;
    check("mac0_din0", bus.mul_din0, 1);
    check("mac0_din1", bus.mul_din1, 3);
    check("mac0_busy", bus.busy, 1);
    lat = 0;
    do begin
      @(posedge ap_clk);
      #1;
      lat++;
    end while (!bus.m_valid && lat < 100);
    check("latency", lat, 16);
    get("coef_same_edge", 1'b1, 16);

    send(16'd7);
    repeat (7) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_m_data", bus.m_data, 0);
    check("midrst_din0", bus.mul_din0, 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge ap_clk);
      #1;
      if (bus.m_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    send(16'd1234);
    get("post_reset_zero", 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
